// File: rtl/audio_feeder_pkg.sv
// Shared types and constants for the audio sample feeder and its FIFO.
package audio_feeder_pkg;

    localparam int DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        F_IDLE  = 2'd0,
        F_REQ   = 2'd1,
        F_FLUSH = 2'd2
    } fetch_state_t;

    typedef enum logic [1:0] {
        O_IDLE = 2'd0,
        O_POPL = 2'd1,
        O_POPR = 2'd2
    } out_state_t;

    // Last valid word address of the playback region; the fetch address wraps after it.
    function automatic int unsigned wrap_limit(input int unsigned sample_num);
        return sample_num - 1;
    endfunction

endpackage

// File: rtl/audio_sync_fifo.sv
// Single-clock FIFO with synchronous active-low reset and a one-cycle flush.
// Popping an empty FIFO is ignored, so a flush racing the output FSM stays safe.
module audio_sync_fifo #(
    parameter int DATA_WIDTH = audio_feeder_pkg::DATA_WIDTH,
    parameter int FIFO_AW    = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_flush,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_head,
    output logic [FIFO_AW:0]      o_level
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] L_FULL = (FIFO_AW + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [FIFO_AW-1:0]    r_wr_ptr;
    logic [FIFO_AW-1:0]    r_rd_ptr;
    logic [FIFO_AW:0]      r_level;
    logic                  w_do_pop;

    assign w_do_pop = i_pop && (r_level != '0);

    // NOTE: the storage array has no reset; pointers and level alone decide which entries are valid.
    always_ff @(posedge i_clk) begin
        if (i_push)
            r_mem[r_wr_ptr] <= i_data;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (i_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({i_push, w_do_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(i_push && !w_do_pop && (r_level == L_FULL)));

    assign o_head  = r_mem[r_rd_ptr];
    assign o_level = r_level;

endmodule

// File: rtl/audio_sample_feeder.sv
// Flow-controlled PCM source: fetch FSM fills a FIFO from memory, output FSM serves sample pairs.
// Build option: define MONO_DUP_EN to treat each word as a mono sample sent to both channels.
module audio_sample_feeder
    import audio_feeder_pkg::*;
#(
    parameter int ADDR_WIDTH = 22,
    parameter int DATA_WIDTH = audio_feeder_pkg::DATA_WIDTH,
    parameter int FIFO_AW    = 4,
    parameter int SAMPLE_NUM = 4194304
) (
    input  logic                  iCLK_18_4,
    input  logic                  iRST_N,
    input  logic                  iEnable,
    output logic [ADDR_WIDTH-1:0] oMEM_ADDR,
    output logic                  oMEM_RD,
    input  logic                  iMEM_VALID,
    input  logic [DATA_WIDTH-1:0] iMEM_DATA,
    input  logic                  iSample_Req,
    output logic [DATA_WIDTH-1:0] oLeft,
    output logic [DATA_WIDTH-1:0] oRight,
    output logic                  oSample_Valid,
    output logic                  oUnderrun,
    output logic [FIFO_AW:0]      oFifo_Level
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0]      L_FILL_MAX  = (FIFO_AW + 1)'(DEPTH - 2);
    localparam logic [ADDR_WIDTH-1:0] L_ADDR_LAST = ADDR_WIDTH'(wrap_limit(SAMPLE_NUM));
`ifdef MONO_DUP_EN
    localparam logic [FIFO_AW:0]      L_PAIR_MIN  = (FIFO_AW + 1)'(1);
`else
    localparam logic [FIFO_AW:0]      L_PAIR_MIN  = (FIFO_AW + 1)'(2);
`endif

    fetch_state_t          r_fetch_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_rd;
    logic                  r_abort;
    out_state_t            r_out_state;
    logic                  r_mute;
    logic [DATA_WIDTH-1:0] r_left_hold;
    logic [DATA_WIDTH-1:0] r_left;
    logic [DATA_WIDTH-1:0] r_right;
    logic                  r_valid;
    logic                  r_underrun;

    logic                  w_abort;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_flush;
    logic                  w_req_accept;
    logic [DATA_WIDTH-1:0] w_head;
    logic [FIFO_AW:0]      w_level;

    // A response for a request that saw iEnable drop is drained and thrown away.
    assign w_abort      = r_abort || !iEnable;
    assign w_push       = (r_fetch_state == F_REQ) && iMEM_VALID && !w_abort;
    assign w_flush      = (r_fetch_state == F_FLUSH);
    assign w_req_accept = (r_out_state == O_IDLE) && iSample_Req;
`ifdef MONO_DUP_EN
    assign w_pop = !r_mute && (r_out_state == O_POPL);
`else
    assign w_pop = !r_mute && ((r_out_state == O_POPL) || (r_out_state == O_POPR));
`endif

    audio_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_AW    (FIFO_AW)
    ) u_fifo (
        .i_clk   (iCLK_18_4),
        .i_rst_n (iRST_N),
        .i_flush (w_flush),
        .i_push  (w_push),
        .i_data  (iMEM_DATA),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_level (w_level)
    );

    always_ff @(posedge iCLK_18_4) begin
        if (!iRST_N) begin
            r_fetch_state <= F_IDLE;
            r_addr        <= '0;
            r_rd          <= 1'b0;
            r_abort       <= 1'b0;
        end else begin
            case (r_fetch_state)
                F_IDLE: begin
                    if (!iEnable) begin
                        r_fetch_state <= F_FLUSH;
                    end else if (w_level <= L_FILL_MAX) begin
                        r_fetch_state <= F_REQ;
                        r_rd          <= 1'b1;
                        r_abort       <= 1'b0;
                    end
                end
                F_REQ: begin
                    if (!iEnable)
                        r_abort <= 1'b1;
                    if (iMEM_VALID) begin
                        r_rd <= 1'b0;
                        if (w_abort) begin
                            r_fetch_state <= F_FLUSH;
                        end else begin
                            r_addr        <= (r_addr == L_ADDR_LAST) ? '0 : r_addr + 1'b1;
                            r_fetch_state <= F_IDLE;
                        end
                    end
                end
                F_FLUSH: begin
                    r_addr        <= '0;
                    r_fetch_state <= F_IDLE;
                end
                default: r_fetch_state <= F_IDLE;
            endcase
        end
    end

    // Mute/underrun is decided once at request time; the pops follow in POPL/POPR.
    always_ff @(posedge iCLK_18_4) begin
        if (!iRST_N) begin
            r_out_state <= O_IDLE;
            r_mute      <= 1'b0;
            r_left_hold <= '0;
            r_left      <= '0;
            r_right     <= '0;
            r_valid     <= 1'b0;
            r_underrun  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_out_state)
                O_IDLE: begin
                    if (iSample_Req) begin
                        r_out_state <= O_POPL;
                        r_mute      <= !iEnable || (w_level < L_PAIR_MIN);
                    end
                end
                O_POPL: begin
                    r_left_hold <= w_head;
                    r_out_state <= O_POPR;
                end
                O_POPR: begin
                    if (r_mute) begin
                        r_left  <= '0;
                        r_right <= '0;
                    end else begin
`ifdef MONO_DUP_EN
                        r_left  <= r_left_hold;
                        r_right <= r_left_hold;
`else
                        r_left  <= r_left_hold;
                        r_right <= w_head;
`endif
                    end
                    r_valid     <= 1'b1;
                    r_out_state <= O_IDLE;
                end
                default: r_out_state <= O_IDLE;
            endcase

            if (w_flush)
                r_underrun <= 1'b0;
            if (w_req_accept && iEnable && (w_level < L_PAIR_MIN))
                r_underrun <= 1'b1;
        end
    end

    assign oMEM_ADDR     = r_addr;
    assign oMEM_RD       = r_rd;
    assign oLeft         = r_left;
    assign oRight        = r_right;
    assign oSample_Valid = r_valid;
    assign oUnderrun     = r_underrun;
    assign oFifo_Level   = w_level;

endmodule

// File: tb/tb_audio_sample_feeder.sv
// Self-checking bench for audio_sample_feeder: directed table, corner sequences, random vs reference model.
module tb_audio_sample_feeder;

    localparam int AW = 22;
    localparam int DW = 16;
    localparam int FAW = 4;
    localparam int SN = 8;
`ifdef MONO_DUP_EN
    localparam int NEED = 1;
`else
    localparam int NEED = 2;
`endif

    logic          clk = 1'b0;
    logic          iRST_N = 1'b0;
    logic          iEnable = 1'b0;
    logic [AW-1:0] oMEM_ADDR;
    logic          oMEM_RD;
    logic          iMEM_VALID = 1'b0;
    logic [DW-1:0] iMEM_DATA = '0;
    logic          iSample_Req = 1'b0;
    logic [DW-1:0] oLeft;
    logic [DW-1:0] oRight;
    logic          oSample_Valid;
    logic          oUnderrun;
    logic [FAW:0]  oFifo_Level;

    always #5 clk = ~clk;

    audio_sample_feeder #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .FIFO_AW    (FAW),
        .SAMPLE_NUM (SN)
    ) dut (
        .iCLK_18_4     (clk),
        .iRST_N        (iRST_N),
        .iEnable       (iEnable),
        .oMEM_ADDR     (oMEM_ADDR),
        .oMEM_RD       (oMEM_RD),
        .iMEM_VALID    (iMEM_VALID),
        .iMEM_DATA     (iMEM_DATA),
        .iSample_Req   (iSample_Req),
        .oLeft         (oLeft),
        .oRight        (oRight),
        .oSample_Valid (oSample_Valid),
        .oUnderrun     (oUnderrun),
        .oFifo_Level   (oFifo_Level)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Memory responder state
    logic [DW-1:0] mem [SN];
    int            mem_budget = 0;   // responses left; negative = unlimited
    int            mem_wait = 0;
    int            lat_min = 1;
    int            lat_max = 1;
    bit            force_valid = 1'b0;
    logic [DW-1:0] force_data = '0;
    int            exp_addr = 0;
    bit            fetch_chk = 1'b0;

    // Reference model: FIFO as a queue of words, requests resolved at acceptance
    bit            model_on = 1'b0;
    logic [DW-1:0] q [$];
    int            vcnt = 0;
    logic [DW-1:0] exp_l = '0;
    logic [DW-1:0] exp_r = '0;
    bit            m_under = 1'b0;

    typedef struct {
        logic          en;
        logic          vld;
        logic [DW-1:0] data;
        logic          rd;
        logic [AW-1:0] addr;
        logic [FAW:0]  lvl;
    } vec_t;

    // One clock: drive inputs for the coming edge, update the model, then sample 1 time unit after it.
    task automatic tick();
        bit resp;
        bit fire;
        resp = 1'b0;
        fire = 1'b0;
        iMEM_VALID = 1'b0;
        if (force_valid) begin
            iMEM_VALID  = 1'b1;
            iMEM_DATA   = force_data;
            force_valid = 1'b0;
        end else if (!oMEM_RD) begin
            mem_wait = $urandom_range(lat_max, lat_min);
        end else if (mem_budget != 0) begin
            if (mem_wait > 0) begin
                mem_wait--;
            end else begin
                resp       = 1'b1;
                iMEM_VALID = 1'b1;
                iMEM_DATA  = mem[oMEM_ADDR[2:0]];
                if (mem_budget > 0) mem_budget--;
                if (fetch_chk) begin
                    check("fetch_addr", oMEM_ADDR, exp_addr);
                    exp_addr = (exp_addr + 1) % SN;
                end
            end
        end
        if (model_on) begin
            if (iSample_Req && vcnt == 0) begin
                vcnt = 3;
                if (q.size() < NEED) begin
                    exp_l = '0;
                    exp_r = '0;
                    m_under = 1'b1;
                end else begin
                    exp_l = q.pop_front();
                    exp_r = (NEED == 2) ? q.pop_front() : exp_l;
                end
            end
            if (resp) q.push_back(iMEM_DATA);
        end
        @(posedge clk);
        #1;
        iSample_Req = 1'b0;
        iMEM_VALID  = 1'b0;
        if (resp) check("rd_drop", oMEM_RD, 1'b0);
        if (model_on) begin
            if (vcnt > 0) begin
                vcnt--;
                fire = (vcnt == 0);
            end
            check("rnd_valid", oSample_Valid, fire);
            check("rnd_under", oUnderrun, m_under);
            if (fire) begin
                check("rnd_left", oLeft, exp_l);
                check("rnd_right", oRight, exp_r);
                check("rnd_level", oFifo_Level, q.size());
            end
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        iRST_N = 1'b0;
        fetch_chk = 1'b0;
        model_on = 1'b0;
        mem_budget = 0;
        ticks(2);
        iRST_N = 1'b1;
        exp_addr = 0;
        q.delete();
        vcnt = 0;
        m_under = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addr"}, oMEM_ADDR, 0);
        check({tag, "_rd"}, oMEM_RD, 0);
        check({tag, "_left"}, oLeft, 0);
        check({tag, "_right"}, oRight, 0);
        check({tag, "_valid"}, oSample_Valid, 0);
        check({tag, "_under"}, oUnderrun, 0);
        check({tag, "_level"}, oFifo_Level, 0);
    endtask

    // Issue one sample request and check the 3-cycle response; elvl < 0 skips the level check.
    task automatic req_and_check(input string tag, input logic [DW-1:0] el, input logic [DW-1:0] er,
                                 input int elvl, input logic eu);
        iSample_Req = 1'b1;
        tick();
        check({tag, "_v1"}, oSample_Valid, 0);
        tick();
        check({tag, "_v2"}, oSample_Valid, 0);
        tick();
        check({tag, "_v3"}, oSample_Valid, 1);
        check({tag, "_left"}, oLeft, el);
        check({tag, "_right"}, oRight, er);
        if (elvl >= 0) check({tag, "_level"}, oFifo_Level, elvl);
        check({tag, "_under"}, oUnderrun, eu);
    endtask

    initial begin
        vec_t vecs [8];
        vecs[0] = '{1'b1, 1'b0, 16'h0000, 1'b1, 22'd0, 5'd0};
        vecs[1] = '{1'b1, 1'b0, 16'h0000, 1'b1, 22'd0, 5'd0};
        vecs[2] = '{1'b1, 1'b1, 16'h1111, 1'b0, 22'd1, 5'd1};
        vecs[3] = '{1'b1, 1'b0, 16'h0000, 1'b1, 22'd1, 5'd1};
        vecs[4] = '{1'b1, 1'b1, 16'h2222, 1'b0, 22'd2, 5'd2};
        vecs[5] = '{1'b1, 1'b1, 16'hDEAD, 1'b1, 22'd2, 5'd2};
        vecs[6] = '{1'b1, 1'b0, 16'h0000, 1'b1, 22'd2, 5'd2};
        vecs[7] = '{1'b1, 1'b1, 16'h3333, 1'b0, 22'd3, 5'd3};
        for (int i = 0; i < SN; i++) mem[i] = 16'h1111 * DW'(i + 1);

        // Reset dominates active enable, request and a stray memory response
        iEnable = 1'b1;
        iSample_Req = 1'b1;
        force_valid = 1'b1;
        force_data = 16'hFFFF;
        tick();
        check_reset_outputs("reset");
        iRST_N = 1'b1;

        // Cycle-exact fetch handshake from the table
        for (int i = 0; i < 8; i++) begin
            iEnable = vecs[i].en;
            if (vecs[i].vld) begin
                force_valid = 1'b1;
                force_data = vecs[i].data;
            end
            tick();
            check($sformatf("vec%0d_rd", i), oMEM_RD, vecs[i].rd);
            check($sformatf("vec%0d_addr", i), oMEM_ADDR, vecs[i].addr);
            check($sformatf("vec%0d_level", i), oFifo_Level, vecs[i].lvl);
        end

        // Continuous fetch: address wraps 7 -> 0 and level saturates at 15
        exp_addr = 3;
        fetch_chk = 1'b1;
        mem_budget = -1;
        ticks(100);
        check("sat_level", oFifo_Level, 15);
        check("sat_rd", oMEM_RD, 0);
        check("sat_addr", oMEM_ADDR, 7);
        check("sat_wrap", exp_addr, 7);
        req_and_check("sat_pair", 16'h1111, (NEED == 2) ? 16'h2222 : 16'h1111, 15 - NEED, 1'b0);

        // Primed FIFO, memory then stalls
        do_reset();
        mem[0] = 16'hAAAA;
        mem[1] = 16'h5555;
        iEnable = 1'b1;
        mem_budget = 2;
        ticks(20);
        check("prime_level", oFifo_Level, 2);
        req_and_check("prime", 16'hAAAA, (NEED == 2) ? 16'h5555 : 16'hAAAA, 2 - NEED, 1'b0);

        // Underrun: not enough words for one output pair
        do_reset();
        iEnable = 1'b1;
        mem_budget = NEED - 1;
        ticks(20);
        check("under_pre_level", oFifo_Level, NEED - 1);
        req_and_check("under", 16'h0000, 16'h0000, NEED - 1, 1'b1);
        ticks(10);
        check("under_sticky", oUnderrun, 1);
        check("under_keep_level", oFifo_Level, NEED - 1);
        check("under_rd_pending", oMEM_RD, 1);

        // Enable drops with a request outstanding; the late response is discarded
        iEnable = 1'b0;
        ticks(5);
        check("abort_rd_hold", oMEM_RD, 1);
        force_valid = 1'b1;
        force_data = 16'hBEEF;
        tick();
        check("abort_rd_drop", oMEM_RD, 0);
        tick();
        check("flush_level", oFifo_Level, 0);
        check("flush_addr", oMEM_ADDR, 0);
        check("flush_under", oUnderrun, 0);
        force_valid = 1'b1;
        force_data = 16'hCAFE;
        ticks(2);
        check("stray_level", oFifo_Level, 0);
        req_and_check("mute_dis", 16'h0000, 16'h0000, 0, 1'b0);

        // Reset in the middle of an outstanding request
        iEnable = 1'b1;
        mem_budget = -1;
        ticks(20);
        req_and_check("pre_rst", 16'hAAAA, (NEED == 2) ? 16'h5555 : 16'hAAAA, -1, 1'b0);
        mem_budget = 0;
        ticks(4);
        check("pre_rst_rd", oMEM_RD, 1);
        iRST_N = 1'b0;
        tick();
        check_reset_outputs("mid_rst");
        iRST_N = 1'b1;
        force_valid = 1'b1;
        force_data = 16'h7777;
        tick();
        check("late_level", oFifo_Level, 0);
        check("late_rd", oMEM_RD, 1);
        check("late_addr", oMEM_ADDR, 0);

        // Random traffic against the reference model
        do_reset();
        for (int i = 0; i < SN; i++) mem[i] = DW'($urandom());
        lat_min = 0;
        lat_max = 3;
        mem_budget = -1;
        iEnable = 1'b1;
        fetch_chk = 1'b1;
        model_on = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            iSample_Req = ($urandom_range((i < 1500) ? 5 : 14, 0) == 0);
            tick();
        end
        ticks(4);
        model_on = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
